// File: rtl/comparador_serial.sv
// comparador_serial: bit-serial magnitude comparator, MSB first.
// A single 1-bit compare cell walks the operands over WIDTH cycles.
// It supports unsigned and two's-complement modes, and it can stop
// early on the first differing bit.
module comparador_serial #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1,
  parameter int CW         = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             modo,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ocupado,
  output logic             pronto,
  output logic             maior,
  output logic             menor,
  output logic             igual,
  output logic [CW-1:0]    bits_analisados
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARA = 2'd1,
    FIM     = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             modo_q, modo_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dif_q, dif_d;       // sticky: a difference has been seen
  logic             dmaior_q, dmaior_d; // decision of the first difference
  logic             maior_q, maior_d;
  logic             menor_q, menor_d;
  logic             igual_q, igual_d;
  logic [CW-1:0]    bits_q, bits_d;
  logic             pronto_q, pronto_d;
  logic             ocupado_q, ocupado_d;

  logic             bit_a, bit_b, differ, msb_signed, cur_maior, finish;

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      modo_q    <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
      dif_q     <= 1'b0;
      dmaior_q  <= 1'b0;
      maior_q   <= 1'b0;
      menor_q   <= 1'b0;
      igual_q   <= 1'b0;
      bits_q    <= '0;
      pronto_q  <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      modo_q    <= modo_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      dif_q     <= dif_d;
      dmaior_q  <= dmaior_d;
      maior_q   <= maior_d;
      menor_q   <= menor_d;
      igual_q   <= igual_d;
      bits_q    <= bits_d;
      pronto_q  <= pronto_d;
      ocupado_q <= ocupado_d;
    end
  end

  // Next-state logic: one bit examined per cycle in COMPARA
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    modo_d    = modo_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    dif_d     = dif_q;
    dmaior_d  = dmaior_q;
    maior_d   = maior_q;
    menor_d   = menor_q;
    igual_d   = igual_q;
    bits_d    = bits_q;

    bit_a      = a_q[idx_q];
    bit_b      = b_q[idx_q];
    differ     = bit_a ^ bit_b;
    // In two's complement the MSB carries negative weight, so its sense flips
    msb_signed = modo_q && (idx_q == IW'(WIDTH - 1));
    cur_maior  = msb_signed ? bit_b : bit_a;
    finish     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          modo_d   = modo;
          idx_d    = IW'(WIDTH - 1);
          cnt_d    = '0;
          dif_d    = 1'b0;
          dmaior_d = 1'b0;
          state_d  = COMPARA;
        end
      end
      COMPARA: begin
        cnt_d = cnt_q + CW'(1);
        if (differ && !dif_q) begin
          dif_d    = 1'b1;
          dmaior_d = cur_maior;
        end
        finish = (differ && (EARLY_EXIT != 0)) || (idx_q == '0);
        if (finish) begin
          state_d = FIM;
          bits_d  = cnt_d;
          if (dif_d) begin
            maior_d = dmaior_d;
            menor_d = ~dmaior_d;
            igual_d = 1'b0;
          end else begin
            maior_d = 1'b0;
            menor_d = 1'b0;
            igual_d = 1'b1;
          end
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      FIM: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are registered from the next state so they align with it
    pronto_d  = (state_d == FIM);
    ocupado_d = (state_d != IDLE);
  end

  assign ocupado         = ocupado_q;
  assign pronto          = pronto_q;
  assign maior           = maior_q;
  assign menor           = menor_q;
  assign igual           = igual_q;
  assign bits_analisados = bits_q;

endmodule
